// File: rtl/down_count_arbiter.sv
// Two-requester round-robin arbiter that runs one down-count per grant.
// Done pulses one cycle after the count reaches zero; abort cancels quietly.
module down_count_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] load0,
  input  logic [WIDTH-1:0] load1,
  input  logic             abort,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [1:0]       done_q, done_d;
  logic             sel;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    count_d = count_q;
    done_d  = 2'b00;
    sel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        count_d = '0;
        if (req != 2'b00) begin
          // both asking: the pointer breaks the tie
          sel     = (req == 2'b11) ? ptr_q : req[1];
          gnt_d   = sel ? 2'b10 : 2'b01;
          count_d = sel ? load1 : load0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort || count_q == '0) begin
          done_d  = abort ? 2'b00 : gnt_q;
          ptr_d   = ~gnt_q[1];
          gnt_d   = 2'b00;
          busy_d  = 1'b0;
          count_d = '0;
          state_d = IDLE;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 2'b00;
      busy_q  <= 1'b0;
      count_q <= '0;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_down_count_arbiter.sv
// Directed vector bench for down_count_arbiter.
// Table rows are one clock each; hand sequences cover async reset.
module tb_down_count_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] load0;
  logic [W-1:0] load1;
  logic         abort;
  logic [1:0]   gnt;
  logic         busy;
  logic [W-1:0] count;
  logic [1:0]   done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic         rst;
    logic [1:0]   req;
    logic [W-1:0] l0;
    logic [W-1:0] l1;
    logic         ab;
    logic [1:0]   gnt;
    logic         busy;
    logic [W-1:0] cnt;
    logic [1:0]   done;
  } vec_t;

  vec_t vq[$];

  down_count_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .load0(load0),
    .load1(load1),
    .abort(abort),
    .gnt  (gnt),
    .busy (busy),
    .count(count),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [1:0] rq,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic ab, input logic [1:0] g,
                     input logic bz, input logic [W-1:0] c,
                     input logic [1:0] d);
    vec_t v;
    v.rst = r; v.req = rq; v.l0 = a; v.l1 = b; v.ab = ab;
    v.gnt = g; v.busy = bz; v.cnt = c; v.done = d;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [1:0] g,
                     input logic bz, input logic [W-1:0] c,
                     input logic [1:0] d);
    n_cmp++;
    if (gnt !== g || busy !== bz || count !== c || done !== d) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b busy=%b count=%0d done=%b, want gnt=%b busy=%b count=%0d done=%b",
               nm, gnt, busy, count, done, g, bz, c, d);
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] rq,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic ab);
    @(negedge clk);
    rst = r; req = rq; load0 = a; load1 = b; abort = ab;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; req = 2'b11; load0 = '0; load1 = '0; abort = 1'b0;
    // reset held with both requesting
    add(0, 2'b11, 5, 5, 0, 2'b00, 0, 0, 2'b00);
    add(0, 2'b11, 5, 5, 0, 2'b00, 0, 0, 2'b00);
    add(1, 2'b00, 5, 5, 0, 2'b00, 0, 0, 2'b00);
    add(1, 2'b00, 5, 5, 1, 2'b00, 0, 0, 2'b00);
    // single requester 0, load 3; later load changes ignored
    add(1, 2'b01, 3, 5, 0, 2'b01, 1, 3, 2'b00);
    add(1, 2'b01, 9, 5, 0, 2'b01, 1, 2, 2'b00);
    add(1, 2'b01, 9, 5, 0, 2'b01, 1, 1, 2'b00);
    add(1, 2'b01, 9, 5, 0, 2'b01, 1, 0, 2'b00);
    add(1, 2'b01, 9, 5, 0, 2'b00, 0, 0, 2'b01);
    add(1, 2'b00, 3, 5, 0, 2'b00, 0, 0, 2'b00);
    // zero load on requester 1
    add(1, 2'b10, 3, 0, 0, 2'b10, 1, 0, 2'b00);
    add(1, 2'b10, 3, 0, 0, 2'b00, 0, 0, 2'b10);
    add(1, 2'b00, 3, 0, 0, 2'b00, 0, 0, 2'b00);
    // contention, ptr=0
    add(1, 2'b11, 1, 2, 0, 2'b01, 1, 1, 2'b00);
    add(1, 2'b11, 1, 2, 0, 2'b01, 1, 0, 2'b00);
    add(1, 2'b11, 1, 2, 0, 2'b00, 0, 0, 2'b01);
    add(1, 2'b10, 1, 2, 0, 2'b10, 1, 2, 2'b00);
    add(1, 2'b10, 1, 2, 0, 2'b10, 1, 1, 2'b00);
    add(1, 2'b10, 1, 2, 0, 2'b10, 1, 0, 2'b00);
    add(1, 2'b10, 1, 2, 0, 2'b00, 0, 0, 2'b10);
    // next contention goes to 0; req dropped mid-run
    add(1, 2'b11, 2, 4, 0, 2'b01, 1, 2, 2'b00);
    add(1, 2'b00, 2, 4, 0, 2'b01, 1, 1, 2'b00);
    add(1, 2'b00, 2, 4, 0, 2'b01, 1, 0, 2'b00);
    add(1, 2'b00, 2, 4, 0, 2'b00, 0, 0, 2'b01);
    // abort at count 3
    add(1, 2'b01, 5, 1, 0, 2'b01, 1, 5, 2'b00);
    add(1, 2'b01, 5, 1, 0, 2'b01, 1, 4, 2'b00);
    add(1, 2'b01, 5, 1, 0, 2'b01, 1, 3, 2'b00);
    add(1, 2'b01, 5, 1, 1, 2'b00, 0, 0, 2'b00);
    // ptr moved to 1 after abort; abort beats completion
    add(1, 2'b11, 5, 1, 0, 2'b10, 1, 1, 2'b00);
    add(1, 2'b11, 5, 1, 0, 2'b10, 1, 0, 2'b00);
    add(1, 2'b11, 5, 1, 1, 2'b00, 0, 0, 2'b00);
    add(1, 2'b00, 5, 1, 0, 2'b00, 0, 0, 2'b00);
    // ptr back to 0
    add(1, 2'b11, 0, 6, 0, 2'b01, 1, 0, 2'b00);
    add(1, 2'b00, 0, 6, 0, 2'b00, 0, 0, 2'b01);
    add(1, 2'b00, 0, 6, 0, 2'b00, 0, 0, 2'b00);

    foreach (vq[i]) begin
      cyc(vq[i].rst, vq[i].req, vq[i].l0, vq[i].l1, vq[i].ab);
      chk($sformatf("vec%0d", i), vq[i].gnt, vq[i].busy,
          vq[i].cnt, vq[i].done);
    end

    // reset mid-run on requester 1 (ptr is 1 here)
    cyc(1, 2'b10, 2, 7, 0);
    chk("rr_grant", 2'b10, 1, 7, 2'b00);
    cyc(1, 2'b10, 2, 7, 0);
    cyc(1, 2'b10, 2, 7, 0);
    cyc(1, 2'b10, 2, 7, 0);
    chk("rr_cnt4", 2'b10, 1, 4, 2'b00);
    @(negedge clk);
    rst = 1'b0; req = 2'b11;
    #1;
    chk("rr_async", 2'b00, 0, 0, 2'b00);
    @(posedge clk);
    #1;
    chk("rr_held", 2'b00, 0, 0, 2'b00);
    cyc(1, 2'b11, 2, 7, 0);
    chk("rr_prio0", 2'b01, 1, 2, 2'b00);
    cyc(1, 2'b00, 2, 7, 0);
    chk("rr_c1", 2'b01, 1, 1, 2'b00);
    cyc(1, 2'b00, 2, 7, 0);
    cyc(1, 2'b00, 2, 7, 0);
    chk("rr_done", 2'b00, 0, 0, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
